uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter TICKS_PER_BIT, default 16, tick16 pulses per UART bit period.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 tick16  input  1  one-clk-wide enable at 16x baud (153600 Hz for 9600 baud), synchronous to clk.
REQ-005 req_valid  input  2  per-requester byte valid (bit0 = requester 0).
REQ-006 req_data  input  16  per-requester byte (req_data[8i+7:8i] for requester i).
REQ-007 req_last  input  2  per-requester: current byte ends its frame.
REQ-008 req_ready  output  2  per-requester: byte accepted this cycle when valid&ready.
REQ-009 grant  output  2  one-hot owner of the transmitter; 0 when unowned.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high whenever the serializer is not IDLE or grant is nonzero.

Function
REQ-012 Serializer states SHALL be IDLE, START, DATA, STOP; frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-013 Each bit SHALL last exactly TICKS_PER_BIT tick16 pulses; bit counter advances only on tick16.
REQ-014 In IDLE with grant==0, the block SHALL grant on the next clk edge to a requester with req_valid high.
REQ-015 Both valid with grant==0: grant SHALL go to the requester not served by the previously completed frame; after reset requester 0 wins.
REQ-016 req_ready[i] SHALL be high only when grant[i]==1 and serializer is IDLE; at most one bit of req_ready high.
REQ-017 On acceptance (valid&ready) in cycle N, the byte SHALL be latched and state SHALL be START with tx=0 from cycle N+1.
REQ-018 DATA->STOP after bit 7 completes; STOP->IDLE after TICKS_PER_BIT tick16 pulses of tx=1.
REQ-019 Grant SHALL remain locked to its owner until a byte accepted with req_last=1 has finished STOP; grant then clears in the same cycle the serializer returns to IDLE.
REQ-020 Owner deasserting req_valid mid-frame: grant SHALL hold, tx SHALL stay high, no timeout; the other requester SHALL remain unserved.
REQ-021 Back-to-back bytes within a frame: next byte accepted in the first IDLE cycle; inter-byte gap is one clk plus tick16 alignment only.
REQ-022 A non-owner's req_valid SHALL never affect tx or req_ready.
REQ-023 tick16 arriving in the acceptance cycle SHALL NOT count toward the start bit.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, tx=1, grant=0, req_ready=0, busy=0, bit/tick counters 0, round-robin priority to requester 0.
REQ-025 Reset mid-frame SHALL abort the frame with no further data bits; operation resumes on the first clk edge after rst_n rises.

Structure
REQ-026 Shared package SHALL hold the serializer state enum, UART_DATA_BITS=8, and default TICKS_PER_BIT=16.
REQ-027 The serializer SHALL be a sub-module uart_tx_serializer (load/ready/tx/tick16 interface); the arbiter and lock logic stay in uart_tx_scheduler.

Verification
REQ-028 Single byte: req0 sends 0xA5 last=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 tick16 wide; grant clears after stop.
REQ-029 Simultaneous: both valid after reset -> req0 frame first, then req1; repeat -> req1 granted first the second time.
REQ-030 Locked frame: req0 sends 3 bytes (last on 3rd) while req1 valid throughout -> req1 sees req_ready=0 until req0's 3rd stop bit completes.
REQ-031 Stall: req0 drops valid after byte 1 of a 2-byte frame for 500 clks -> tx stays 1, grant stays 01, req1 not served.
REQ-032 Reset mid-DATA (after bit 3): tx=1 and grant=0 immediately; new 0x3C from req1 then transmits correctly.
REQ-033 tick16 coincident with acceptance -> start bit still exactly 16 tick16 pulses long.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// ============================================================================
// Module   : uart_tx_scheduler_pkg
// Brief    : Shared types and constants for the two-requester UART scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_tx_scheduler_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int DEFAULT_TICKS_PER_BIT = 16;
    localparam int NUM_REQ               = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_e;

    // A tie goes to whichever requester did not own the last finished frame.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic               prev_owner
    );
        logic [NUM_REQ-1:0] pick;
        pick = valid;
        if (valid == 2'b11) begin
            pick = prev_owner ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : 8N1 UART bit serializer clocked by a 16x-baud tick enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_tx_scheduler_pkg::*;
#(
    parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick16_i,
    input  logic                      load_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic                      tx_o
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    ser_state_e                state_q;
    logic [TW-1:0]             tick_cnt_q;
    logic [BW-1:0]             bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      tx_q;
    logic                      w_bit_end;

    assign w_bit_end = tick16_i && (tick_cnt_q == TICK_LAST);
    assign ready_o   = (state_q == ST_IDLE);
    assign done_o    = (state_q == ST_STOP) && w_bit_end;
    assign tx_o      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            // The tick counter only runs once the start bit is on the line,
            // so a tick coinciding with the load is ignored.
            if (state_q != ST_IDLE && tick16_i) begin
                tick_cnt_q <= w_bit_end ? '0 : tick_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        shift_q    <= data_i;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Two-requester arbiter with frame locking in front of a UART TX.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick16,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*UART_DATA_BITS-1:0]  req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               tx,
    output logic                               busy
);

    logic [NUM_REQ-1:0]        grant_q;
    logic                      last_pend_q;
    logic                      prev_owner_q;

    logic                      w_owner;
    logic                      w_ser_ready;
    logic                      w_ser_done;
    logic                      w_load;
    logic [UART_DATA_BITS-1:0] w_load_data;

    assign w_owner     = grant_q[1];
    assign req_ready   = grant_q & {NUM_REQ{w_ser_ready}};
    assign w_load      = |(req_valid & req_ready);
    assign w_load_data = w_owner ? req_data[15:8] : req_data[7:0];
    assign grant       = grant_q;
    assign busy        = !w_ser_ready || (grant_q != '0);

    uart_tx_serializer #(
        .TICKS_PER_BIT (TICKS_PER_BIT)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick16_i (tick16),
        .load_i   (w_load),
        .data_i   (w_load_data),
        .ready_o  (w_ser_ready),
        .done_o   (w_ser_done),
        .tx_o     (tx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            last_pend_q  <= 1'b0;
            // Pretend requester 1 finished last so requester 0 wins the first tie.
            prev_owner_q <= 1'b1;
        end else begin
            if (w_load) begin
                last_pend_q <= req_last[w_owner];
            end
            if (w_ser_done && last_pend_q) begin
                grant_q      <= '0;
                last_pend_q  <= 1'b0;
                prev_owner_q <= w_owner;
            end else if (grant_q == '0 && w_ser_ready) begin
                grant_q <= rr_pick(req_valid, prev_owner_q);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Directed and randomized bench against a tick-counting reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    localparam int TPB    = 16;
    localparam int BUDGET = 6000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        tick16    = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_last  = 2'b00;
    logic [15:0] req_data  = 16'h0000;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int tdiv  = 1;
    int tcnt  = 0;
    bit tick_rand = 1'b0;
    bit watch_r1  = 1'b0;
    int r1_seen   = 0;

    uart_tx_scheduler #(.TICKS_PER_BIT(TPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick16    (tick16),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_rand) begin
                tick16 = ($urandom_range(0, 1) == 1);
            end else begin
                tick16 = (tcnt == 0);
                tcnt   = (tcnt + 1 >= tdiv) ? 0 : tcnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is 10 bit slots; the line shows slot (ticks/TPB),
    // counting only ticks seen after the accepting edge.
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [1:0] m_grant  = 2'b00;
    bit         m_last   = 1'b0;
    int         m_prev   = 1;

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int o;
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_grant = 2'b00; m_last = 1'b0; m_prev = 1;
        end else if (m_active) begin
            if (tick16) m_k++;
            if (m_k == 10 * TPB) begin
                m_active = 1'b0;
                if (m_last) begin
                    m_prev  = m_grant[1] ? 1 : 0;
                    m_grant = 2'b00;
                    m_last  = 1'b0;
                end
            end
        end else if (m_grant != 2'b00) begin
            o = m_grant[1] ? 1 : 0;
            if (req_valid[o]) begin
                m_active = 1'b1;
                m_k      = 0;
                m_byte   = req_data[8*o +: 8];
                m_last   = req_last[o];
            end
        end else if (req_valid == 2'b11) begin
            m_grant = (m_prev == 0) ? 2'b10 : 2'b01;
        end else if (req_valid != 2'b00) begin
            m_grant = req_valid;
        end
    end

    always @(negedge clk) begin
        logic [1:0] er;
        logic       et;
        er = m_active ? 2'b00 : m_grant;
        et = m_active ? frame_bit(m_byte, m_k / TPB) : 1'b1;
        chk("tx", 32'(tx), 32'(et));
        chk("grant", 32'(grant), 32'(m_grant));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_active || (m_grant != 2'b00)));
        if (watch_r1 && req_ready[1]) r1_seen++;
    end

    task automatic accept(input int i);
        int n = 0;
        while (req_ready[i] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_budget", 32'(n < BUDGET), 32'd1);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l);
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
        req_valid[i]       = 1'b1;
        accept(i);
    endtask

    task automatic wait_grant_not(input logic [1:0] g);
        int n = 0;
        while (grant === g && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("grant_change_in_budget", 32'(n < BUDGET), 32'd1);
    endtask

    // Samples the line mid-slot; call at the first negedge after acceptance.
    task automatic collect(output logic [9:0] v, input int stop);
        int         k = 0;
        int         n = 0;
        bit         t;
        logic [9:0] taken = '0;
        v = '0;
        while (k < stop && n < BUDGET) begin
            if ((k % TPB) == TPB / 2 && !taken[k / TPB]) begin
                v[k / TPB]     = tx;
                taken[k / TPB] = 1'b1;
            end
            t = tick16;
            @(negedge clk);
            n++;
            if (t) k++;
        end
        chk("collect_in_budget", 32'(n < BUDGET), 32'd1);
    endtask

    initial begin
        logic [9:0] v;
        int         cnt;
        int         sbad;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Tick on every clock, so one lands on the accepting edge.
        tdiv = 1;
        send(0, 8'hA5, 1'b1);
        cnt = 0;
        while (tx === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("start_bit_ticks", 32'(cnt), 32'd16);
        wait_grant_not(2'b01);

        tdiv = 3;
        @(negedge clk);
        send(0, 8'hA5, 1'b1);
        collect(v, 160);
        chk("frame_a5", 32'(v), 32'b1101001010);
        chk("grant_clear_after_stop", 32'(grant), 32'd0);
        chk("tx_idle_after_stop", 32'(tx), 32'd1);

        tdiv = 2;
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        req_data = 16'h2211; req_last = 2'b11; req_valid = 2'b11;
        @(negedge clk);
        chk("tie_first_req0", 32'(grant), 32'b01);
        accept(0); req_valid[0] = 1'b1;
        wait_grant_not(2'b01); @(negedge clk);
        chk("tie_second_req1", 32'(grant), 32'b10);
        accept(1); req_valid[1] = 1'b1;
        wait_grant_not(2'b10); @(negedge clk);
        chk("tie_third_req0", 32'(grant), 32'b01);
        accept(0); req_valid[1] = 1'b0;
        wait_grant_not(2'b01);

        tdiv = 1;
        req_data[7:0] = 8'h01; req_last[0] = 1'b0; req_valid[0] = 1'b1;
        @(negedge clk);
        req_data[15:8] = 8'h5A; req_last[1] = 1'b1; req_valid[1] = 1'b1;
        watch_r1 = 1'b1;
        accept(0);
        send(0, 8'h02, 1'b0);
        send(0, 8'h03, 1'b1);
        wait_grant_not(2'b01);
        watch_r1 = 1'b0;
        chk("locked_r1_never_ready", 32'(r1_seen), 32'd0);
        @(negedge clk);
        chk("locked_then_r1", 32'(grant), 32'b10);
        accept(1);
        wait_grant_not(2'b10);

        tdiv = 2;
        req_data[7:0] = 8'h77; req_last[0] = 1'b0; req_valid[0] = 1'b1;
        @(negedge clk);
        req_data[15:8] = 8'h66; req_last[1] = 1'b1; req_valid[1] = 1'b1;
        accept(0);
        sbad = 0;
        for (int c = 0; c < 500; c++) begin
            if (c >= 400 && (tx !== 1'b1 || grant !== 2'b01 || req_ready[1] !== 1'b0)) sbad++;
            @(negedge clk);
        end
        chk("stall_holds", 32'(sbad), 32'd0);
        chk("stall_owner_ready", 32'(req_ready), 32'b01);
        send(0, 8'h78, 1'b1);
        wait_grant_not(2'b01); @(negedge clk);
        chk("stall_then_r1", 32'(grant), 32'b10);
        accept(1);
        wait_grant_not(2'b10);

        @(negedge clk);
        send(0, 8'h00, 1'b1);
        collect(v, 80);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_grant", 32'(grant), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        send(1, 8'h3C, 1'b1);
        collect(v, 160);
        chk("frame_3c", 32'(v), 32'b1001111000);
        chk("grant_clear_3c", 32'(grant), 32'd0);

        tick_rand = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                end
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = ($urandom_range(0, 2) == 0);
            end
            if (c == 9000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
